// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width, FSM states and
// the helper that sizes the bit counter.
package bit_serial_adder_pkg;

    // Default operand / sum width in bits (legal range 2..32).
    localparam int DEF_WIDTH = 8;

    // Counter width for the default configuration: $clog2(WIDTH).
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    // Sequencer states: waiting for a request, or shifting bits through the cell.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit-counter width for an arbitrary WIDTH; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// Single-bit gate-level full adder. Purely combinational; the surrounding
// sequencer registers its carry back into cin.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic ab_xor;
    logic ab_and;
    logic prop_and;

    // Classic two half-adder structure built from xor/and/or gates.
    xor g_x1 (ab_xor, a, b);
    xor g_x2 (sum, ab_xor, cin);
    and g_a1 (ab_and, a, b);
    and g_a2 (prop_and, ab_xor, cin);
    or  g_o1 (carry, ab_and, prop_and);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
// then one bit pair per clock (LSB first) is fed through a single full-adder
// cell with its carry registered back. After WIDTH bits the result and
// carry-out are published together with a one-cycle done pulse.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             cell_sum;
    logic             cell_carry;
    logic             last_bit;

    // The one shared full-adder cell, fed from the operand LSBs and the
    // registered carry.
    fa_cell u_fa_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry_q),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign last_bit = (cnt == LAST_CNT);

    // busy is a decode of the state flop, so it is registered too.
    assign busy = (state == RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with <= so every flop samples
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept a request in IDLE, return after the last bit.
    always_comb begin
        // NOTE: default first, so no path leaves next_state unassigned and
        // no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = RUN;
            RUN:     if (last_bit) next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Datapath: operand load, per-bit shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every datapath register is plain flops (no RAM), so all of
        // them are cleared by the async reset, which also drops any
        // addition in flight without a done pulse.
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a_in;
                        b_sr    <= b_in;
                        carry_q <= cin_in;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_sr  <= {cell_sum, sum_sr[WIDTH-1:1]};
                    carry_q <= cell_carry;
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_out  <= {cell_sum, sum_sr[WIDTH-1:1]};
                        cout_out <= cell_carry;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
